// File: rtl/local_mem_sweep_pkg.sv
// Shared definitions for the local-memory sweep sequencer:
// command word layout, FSM states and the test pattern.
package local_mem_sweep_pkg;

  localparam int CTRL_RD  = 0;
  localparam int CTRL_WR  = 1;
  localparam int BANK_LO  = 2;
  localparam int BANK_HI  = 3;
  localparam int BE_LO    = 4;
  localparam int BE_HI    = 11;
  localparam int WSEL_LO  = 16;
  localparam int WSEL_HI  = 18;
  localparam int BURST_LO = 20;
  localparam int BURST_HI = 26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_GAP,
    S_RD_ISSUE,
    S_RD_GUARD,
    S_RD_WAIT,
    S_CHECK,
    S_DONE
  } t_sweep_state;

  function automatic logic [63:0] sweep_pattern(
    input logic [63:0] addr,
    input logic [63:0] seed
  );
    return seed ^ {addr[31:0], ~addr[31:0]};
  endfunction

endpackage

// File: rtl/local_mem_sweep_if.sv
// Command/response bus between the sweep sequencer
// and the CSR-driven local-memory access block.
interface local_mem_sweep_if #(
  parameter int DATA_WIDTH = 64
);

  logic [DATA_WIDTH-1:0] cr2mem_ctrl;
  logic [DATA_WIDTH-1:0] cr2mem_address;
  logic [DATA_WIDTH-1:0] cr2mem_writedata;
  logic [DATA_WIDTH-1:0] mem2cr_readdata;
  logic [DATA_WIDTH-1:0] mem2cr_status;

  modport master (
    output cr2mem_ctrl,
    output cr2mem_address,
    output cr2mem_writedata,
    input  mem2cr_readdata,
    input  mem2cr_status
  );

  modport slave (
    input  cr2mem_ctrl,
    input  cr2mem_address,
    input  cr2mem_writedata,
    output mem2cr_readdata,
    output mem2cr_status
  );

endinterface

// File: rtl/local_mem_sweep_cmd_fmt.sv
// Command formatter: registers ctrl/address/writedata
// and turns issue requests into one-cycle strobes.
module local_mem_sweep_cmd_fmt
  import local_mem_sweep_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  SoftReset,
  input  logic                  issue_wr,
  input  logic                  issue_rd,
  input  logic [1:0]            bank,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] writedata
);

  logic [DATA_WIDTH-1:0] word;

  // assemble the full command word for the next issue
  always_comb begin
    word = '0;
    word[BANK_HI:BANK_LO]   = bank;
    word[BE_HI:BE_LO]       = 8'hFF;
    word[WSEL_HI:WSEL_LO]   = addr[2:0];
    word[BURST_HI:BURST_LO] = 7'd1;
    word[CTRL_WR]           = issue_wr;
    word[CTRL_RD]           = issue_rd;
  end

  // load on issue; otherwise drop strobes, hold the rest
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      ctrl      <= '0;
      address   <= '0;
      writedata <= '0;
    end else if (issue_wr || issue_rd) begin
      ctrl    <= word;
      address <= addr;
      if (issue_wr) writedata <= wdata;
    end else begin
      ctrl[CTRL_WR] <= 1'b0;
      ctrl[CTRL_RD] <= 1'b0;
    end
  end

endmodule

// File: rtl/local_mem_sweep_seq.sv
// Write-then-readback sweep sequencer over one bank
// of the local-memory access block.
module local_mem_sweep_seq
  import local_mem_sweep_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int COUNT_WIDTH    = 32,
  parameter int WR_GAP         = 8,
  parameter int RD_GUARD       = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   SoftReset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             cfg_bank,
  input  logic [DATA_WIDTH-1:0]  cfg_base,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic [DATA_WIDTH-1:0]  cfg_seed,
  local_mem_sweep_if.master      mem,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic [DATA_WIDTH-1:0]  first_fail_addr
);

  t_sweep_state           state;
  logic [1:0]             bank_q;
  logic [DATA_WIDTH-1:0]  base_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0]  seed_q;
  logic [COUNT_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  rd_q;
  logic [31:0]            tmr;
  logic                   aborted;
  logic                   last;
  logic                   issue_wr;
  logic                   issue_rd;
  logic [DATA_WIDTH-1:0]  ctrl;
  logic [DATA_WIDTH-1:0]  address;
  logic [DATA_WIDTH-1:0]  writedata;
  logic                   unused_status;

  assign last     = (idx == count_q - 1'b1);
  assign issue_wr = (state == S_WR_ISSUE);
  assign issue_rd = (state == S_RD_ISSUE);

  assign unused_status = ^mem.mem2cr_status[DATA_WIDTH-1:1];

  assign mem.cr2mem_ctrl      = ctrl;
  assign mem.cr2mem_address   = address;
  assign mem.cr2mem_writedata = writedata;

  local_mem_sweep_cmd_fmt #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmd_fmt (
    .clk       (clk),
    .SoftReset (SoftReset),
    .issue_wr  (issue_wr),
    .issue_rd  (issue_rd),
    .bank      (bank_q),
    .addr      (addr_q),
    .wdata     (sweep_pattern(addr_q, seed_q)),
    .ctrl      (ctrl),
    .address   (address),
    .writedata (writedata)
  );

  // sweep FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      state           <= S_IDLE;
      bank_q          <= '0;
      base_q          <= '0;
      count_q         <= '0;
      seed_q          <= '0;
      idx             <= '0;
      addr_q          <= '0;
      rd_q            <= '0;
      tmr             <= '0;
      aborted         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            aborted         <= 1'b0;
            bank_q          <= cfg_bank;
            base_q          <= cfg_base;
            count_q         <= cfg_count;
            seed_q          <= cfg_seed;
            idx             <= '0;
            addr_q          <= cfg_base;
            tmr             <= '0;
            if (cfg_count == '0) begin
              state <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_WR_ISSUE;
            end
          end
        end
        S_WR_ISSUE: begin
          tmr   <= '0;
          state <= S_WR_GAP;
        end
        S_WR_GAP: begin
          if (abort) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else if (tmr == 32'(WR_GAP - 1)) begin
            tmr <= '0;
            if (last) begin
              idx    <= '0;
              addr_q <= base_q;
              state  <= S_RD_ISSUE;
            end else begin
              idx    <= idx + 1'b1;
              addr_q <= addr_q + 1'b1;
              state  <= S_WR_ISSUE;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_RD_ISSUE: begin
          tmr   <= '0;
          state <= S_RD_GUARD;
        end
        S_RD_GUARD: begin
          if (tmr == 32'(RD_GUARD - 1)) begin
            tmr   <= '0;
            state <= S_RD_WAIT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (abort) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else if (mem.mem2cr_status[0]) begin
            rd_q  <= mem.mem2cr_readdata;
            state <= S_CHECK;
          end else if (tmr == 32'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_CHECK: begin
          if (rd_q != sweep_pattern(addr_q, seed_q)) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) first_fail_addr <= addr_q;
          end
          if (abort) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else if (last) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            idx    <= idx + 1'b1;
            addr_q <= addr_q + 1'b1;
            state  <= S_RD_ISSUE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          pass  <= !timeout && (err_count == '0) && !aborted;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_mem_sweep_seq.sv
// Bench for local_mem_sweep_seq: memory model, strobe
// scoreboard, vector table and multi-cycle corner cases.
module tb_local_mem_sweep_seq;

  localparam int DW = 64;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          SoftReset;
  logic          start;
  logic          abort;
  logic [1:0]    cfg_bank;
  logic [DW-1:0] cfg_base;
  logic [CW-1:0] cfg_count;
  logic [DW-1:0] cfg_seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [CW-1:0] err_count;
  logic [DW-1:0] first_fail_addr;

  local_mem_sweep_if #(.DATA_WIDTH(DW)) bus ();

  local_mem_sweep_seq #(
    .DATA_WIDTH(DW),
    .COUNT_WIDTH(CW),
    .WR_GAP(8),
    .RD_GUARD(4),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk             (clk),
    .SoftReset       (SoftReset),
    .start           (start),
    .abort           (abort),
    .cfg_bank        (cfg_bank),
    .cfg_base        (cfg_base),
    .cfg_count       (cfg_count),
    .cfg_seed        (cfg_seed),
    .mem             (bus),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timeout         (timeout),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [63:0] a,
                                      input logic [63:0] s);
    return s ^ {a[31:0], ~a[31:0]};
  endfunction

  function automatic logic [63:0] ctrl_word(input logic wr,
                                            input logic [1:0] bk,
                                            input logic [63:0] a);
    logic [63:0] w;
    w = '0;
    w[1]     = wr;
    w[0]     = !wr;
    w[3:2]   = bk;
    w[11:4]  = 8'hFF;
    w[18:16] = a[2:0];
    w[26:20] = 7'd1;
    return w;
  endfunction

  typedef struct packed {
    logic        wr;
    logic [1:0]  bank;
    logic [63:0] addr;
    logic [63:0] data;
  } cmd_t;

  cmd_t exp_q[$];

  // scoreboard: every strobe must match the next expected command
  always @(negedge clk) begin
    cmd_t e;
    if (!SoftReset && (bus.cr2mem_ctrl[1] || bus.cr2mem_ctrl[0])) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: ctrl %h addr %h",
                 bus.cr2mem_ctrl, bus.cr2mem_address);
      end else begin
        e = exp_q.pop_front();
        check("ctrl", bus.cr2mem_ctrl, ctrl_word(e.wr, e.bank, e.addr));
        check("address", bus.cr2mem_address, e.addr);
        if (e.wr) check("writedata", bus.cr2mem_writedata, e.data);
      end
    end
  end

  logic [63:0] mem [logic [63:0]];
  logic [63:0] flip_a;
  logic [63:0] flip_b;
  logic [1:0]  flip_en;
  int          novalid_nth;
  int          cd;
  int          rd_n;
  logic        noresp;
  logic [63:0] rd_addr;

  // memory model: sticky valid, stale valid clears at +3, data at +6
  always @(negedge clk) begin
    logic [63:0] v;
    if (SoftReset) begin
      cd = 0;
      rd_n = 0;
      noresp = 1'b0;
      bus.mem2cr_status = '0;
      bus.mem2cr_readdata = '0;
    end else begin
      if (bus.cr2mem_ctrl[1]) begin
        mem[bus.cr2mem_address] = bus.cr2mem_writedata;
        rd_n = 0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 3) bus.mem2cr_status = '0;
        if (cd == 0 && !noresp) begin
          v = mem.exists(rd_addr) ? mem[rd_addr] : 64'h0;
          if (flip_en[0] && rd_addr == flip_a) v[0] = ~v[0];
          if (flip_en[1] && rd_addr == flip_b) v[0] = ~v[0];
          bus.mem2cr_readdata = v;
          bus.mem2cr_status = 64'h1;
        end
      end
      if (bus.cr2mem_ctrl[0]) begin
        rd_n++;
        rd_addr = bus.cr2mem_address;
        cd = 6;
        noresp = (rd_n == novalid_nth);
      end
    end
  end

  typedef struct {
    logic [1:0]  bank;
    logic [63:0] base;
    int          count;
    logic [63:0] seed;
    logic [1:0]  fen;
    logic [63:0] fa;
    logic [63:0] fb;
    int          novalid;
    logic        ab;
    logic        e_pass;
    int          e_err;
    logic [63:0] e_ffa;
    logic        e_to;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input logic [1:0] bk, input logic [63:0] b,
                            input int n, input int nrd,
                            input logic [63:0] s);
    cmd_t c;
    for (int i = 0; i < n; i++) begin
      c.wr = 1'b1; c.bank = bk; c.addr = b + 64'(i);
      c.data = pat(c.addr, s);
      exp_q.push_back(c);
    end
    for (int i = 0; i < nrd; i++) begin
      c.wr = 1'b0; c.bank = bk; c.addr = b + 64'(i); c.data = '0;
      exp_q.push_back(c);
    end
  endtask

  task automatic pulse_start(input logic with_abort);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (!done && cyc < 20000) begin
      tick();
      cyc++;
    end
    check({name, "_done"}, {63'd0, done}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int cyc;
    string nm;
    nm = $sformatf("vec%0d", k);
    flip_en = v.fen;
    flip_a = v.fa;
    flip_b = v.fb;
    novalid_nth = v.novalid;
    push_sweep(v.bank, v.base, v.count,
               (v.novalid == 0) ? v.count : v.novalid, v.seed);
    cfg_bank = v.bank;
    cfg_base = v.base;
    cfg_count = CW'(v.count);
    cfg_seed = v.seed;
    pulse_start(v.ab);
    wait_done(nm, cyc);
    check({nm, "_pass"}, {63'd0, pass}, {63'd0, v.e_pass});
    check({nm, "_err"}, 64'(err_count), 64'(v.e_err));
    check({nm, "_ffa"}, first_fail_addr, v.e_ffa);
    check({nm, "_timeout"}, {63'd0, timeout}, {63'd0, v.e_to});
    check({nm, "_busy"}, {63'd0, busy}, 64'd0);
    check({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
    if (v.e_to) check({nm, "_to_len"}, 64'(cyc > 4096), 64'd1);
    exp_q.delete();
    repeat (3) tick();
  endtask

  initial begin
    int cyc;
    vecs[0] = '{2'd0, 64'h100, 4, 64'h0, 2'b00, 64'h0, 64'h0,
                0, 1'b1, 1'b1, 0, 64'h0, 1'b0};
    vecs[1] = '{2'd1, 64'h100, 4, 64'hDEADBEEF_12345678, 2'b01,
                64'h102, 64'h0, 0, 1'b0, 1'b0, 1, 64'h102, 1'b0};
    vecs[2] = '{2'd2, 64'h100, 4, 64'h0F0F, 2'b00, 64'h0, 64'h0,
                2, 1'b0, 1'b0, 0, 64'h0, 1'b1};
    vecs[3] = '{2'd0, 64'h180, 0, 64'h0, 2'b00, 64'h0, 64'h0,
                0, 1'b0, 1'b1, 0, 64'h0, 1'b0};
    vecs[4] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFE, 3,
                64'hA5A5_5A5A_0123_4567, 2'b00, 64'h0, 64'h0,
                0, 1'b0, 1'b1, 0, 64'h0, 1'b0};
    vecs[5] = '{2'd1, 64'h200, 5, 64'h55, 2'b11, 64'h201, 64'h203,
                0, 1'b0, 1'b0, 2, 64'h201, 1'b0};

    SoftReset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_bank = '0;
    cfg_base = '0;
    cfg_count = '0;
    cfg_seed = '0;
    flip_en = '0;
    flip_a = '0;
    flip_b = '0;
    novalid_nth = 0;
    repeat (3) tick();
    check("rst_ctrl", bus.cr2mem_ctrl, 64'h0);
    check("rst_addr", bus.cr2mem_address, 64'h0);
    check("rst_wdata", bus.cr2mem_writedata, 64'h0);
    check("rst_flags", {60'd0, busy, done, pass, timeout}, 64'h0);
    check("rst_err", 64'(err_count), 64'h0);
    check("rst_ffa", first_fail_addr, 64'h0);
    SoftReset = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    cfg_count = '0;
    cfg_base = 64'h40;
    pulse_start(1'b0);
    check("cnt0_c1_done", {63'd0, done}, 64'd0);
    check("cnt0_c1_busy", {63'd0, busy}, 64'd0);
    tick();
    check("cnt0_c2_done", {63'd0, done}, 64'd1);
    check("cnt0_c2_pass", {63'd0, pass}, 64'd1);
    repeat (3) tick();

    novalid_nth = 1;
    flip_en = '0;
    push_sweep(2'd2, 64'h400, 2, 1, 64'h77);
    cfg_bank = 2'd2;
    cfg_base = 64'h400;
    cfg_count = 2;
    cfg_seed = 64'h77;
    pulse_start(1'b0);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("srst_rd_seen", 64'(exp_q.size()), 64'd0);
    repeat (8) tick();
    check("srst_busy_before", {63'd0, busy}, 64'd1);
    SoftReset = 1'b1;
    tick();
    check("srst_ctrl", bus.cr2mem_ctrl, 64'h0);
    check("srst_flags", {60'd0, busy, done, pass, timeout}, 64'h0);
    check("srst_err", 64'(err_count), 64'h0);
    SoftReset = 1'b0;
    exp_q.delete();
    tick();
    vecs[0].ab = 1'b0;
    vecs[0].base = 64'h400;
    vecs[0].count = 2;
    run_vec(vecs[0], 6);

    novalid_nth = 0;
    push_sweep(2'd1, 64'h300, 1, 0, 64'h9);
    cfg_bank = 2'd1;
    cfg_base = 64'h300;
    cfg_count = 4;
    cfg_seed = 64'h9;
    pulse_start(1'b0);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("abort_wr_seen", 64'(exp_q.size()), 64'd0);
    cfg_count = 1;
    pulse_start(1'b0);
    check("abort_busy_kept", {63'd0, busy}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("abort", cyc);
    check("abort_pass", {63'd0, pass}, 64'd0);
    check("abort_timeout", {63'd0, timeout}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    repeat (30) tick();
    check("abort_pending", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
